// File: rtl/cpu31_pkg.sv
// Shared definitions for the 31-instruction MIPS core: sequencer state encodings,
// PC-source codes, one-hot decoded-instruction bit positions and the legality check.
package cpu31_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IF    = 3'd1,
    ST_ID    = 3'd2,
    ST_EX    = 3'd3,
    ST_MEM   = 3'd4,
    ST_WB    = 3'd5,
    ST_HALT  = 3'd6,
    ST_FAULT = 3'd7
  } state_e;

  localparam logic [1:0] PC_NPC = 2'b00;
  localparam logic [1:0] PC_RS  = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  // R-type ALU ops occupy bits 0..9
  localparam int I_ADD   = 0;
  localparam int I_ADDU  = 1;
  localparam int I_SUB   = 2;
  localparam int I_SUBU  = 3;
  localparam int I_AND   = 4;
  localparam int I_OR    = 5;
  localparam int I_XOR   = 6;
  localparam int I_NOR   = 7;
  localparam int I_SLT   = 8;
  localparam int I_SLTU  = 9;
  localparam int I_SLL   = 10;
  localparam int I_SRL   = 11;
  localparam int I_SRA   = 12;
  localparam int I_SLLV  = 13;
  localparam int I_SRLV  = 14;
  localparam int I_SRAV  = 15;
  localparam int I_JR    = 16;
  localparam int I_ADDI  = 17;
  localparam int I_ADDIU = 18;
  localparam int I_ANDI  = 19;
  localparam int I_ORI   = 20;
  localparam int I_XORI  = 21;
  localparam int I_LUI   = 22;
  localparam int I_LW    = 23;
  localparam int I_SW    = 24;
  localparam int I_BEQ   = 25;
  localparam int I_BNE   = 26;
  localparam int I_SLTI  = 27;
  localparam int I_SLTIU = 28;
  localparam int I_J     = 29;
  localparam int I_JAL   = 30;

  localparam logic [31:0] VALID_MASK = 32'h7FFF_FFFF;

  // True when exactly one bit is set and it lies inside VALID_MASK.
  function automatic logic is_onehot_valid(input logic [31:0] v);
    logic [31:0] m;
    m = v & VALID_MASK;
    return (v == m) && (m != 32'd0) && ((m & (m - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter shared by the fetch and data-memory phases; flags the cycle in
// which an unanswered request reaches MAX_WAIT.
module mem_wait_timer #(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // This cycle would be the MAX_WAIT-th unanswered one.
  assign timeout_o = en_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer: decides when PC, IR and the register
// file update and drives the fetch / data-memory request strobes.
module multicycle_sequencer
  import cpu31_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] decoded_instr,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        ir_w,
  output logic        pc_w,
  output logic [1:0]  pc_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        regfile_w,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        fault,
  output logic        halted
);

  // Handshake: a request (imem_req/dmem_req) stays high for its whole state; the access
  // completes in the first cycle the matching ready is high. ready is ignored elsewhere.

  state_e state_q, state_d;
  logic   retire;
  logic   wait_en;
  logic   wait_clr;
  logic   timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    pc_sel     = PC_NPC;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    regfile_w  = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    halted     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      ST_IDLE: state_d = halt_req ? ST_HALT : ST_IF;
      ST_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = ST_ID;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_ID: begin
        if (!is_onehot_valid(decoded_instr)) begin
          state_d = ST_FAULT;
        end else if (decoded_instr[I_J] || decoded_instr[I_JAL]) begin
          pc_w   = 1'b1;
          pc_sel = PC_JMP;
          if (decoded_instr[I_JAL]) state_d = ST_WB;
          else                      retire  = 1'b1;
        end else if (decoded_instr[I_JR]) begin
          pc_w   = 1'b1;
          pc_sel = PC_RS;
          retire = 1'b1;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        if (decoded_instr[I_BEQ] || decoded_instr[I_BNE]) begin
          if ((decoded_instr[I_BEQ] && alu_zero) || (decoded_instr[I_BNE] && !alu_zero)) begin
            pc_w   = 1'b1;
            pc_sel = PC_BR;
          end
          retire = 1'b1;
        end else if (decoded_instr[I_LW] || decoded_instr[I_SW]) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = decoded_instr[I_SW];
        if (dmem_ready) begin
          if (decoded_instr[I_SW]) retire  = 1'b1;
          else                     state_d = ST_WB;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        regfile_w = 1'b1;
        retire    = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_d = ST_IF;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_d = ST_FAULT;
    endcase
    // halt_req only takes effect at an instruction boundary
    if (retire) begin
      instr_done = 1'b1;
      state_d    = halt_req ? ST_HALT : ST_IF;
    end
  end

  assign wait_en  = ((state_q == ST_IF) && !imem_ready) || ((state_q == ST_MEM) && !dmem_ready);
  // Any state change clears the counter, so IF and MEM always start from zero.
  assign wait_clr = (state_d != state_q);

  mem_wait_timer #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wait_clr),
    .en_i     (wait_en),
    .timeout_o(timeout)
  );

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle state/strobe vectors per scenario.
module tb_multicycle_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] decoded_instr;
  logic        alu_zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        halt_req;
  logic        imem_req;
  logic        ir_w;
  logic        pc_w;
  logic [1:0]  pc_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        regfile_w;
  logic [2:0]  state;
  logic        instr_done;
  logic        fault;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] OP_ADD = 32'h0000_0001;
  localparam logic [31:0] OP_JR  = 32'h0001_0000;
  localparam logic [31:0] OP_LW  = 32'h0080_0000;
  localparam logic [31:0] OP_SW  = 32'h0100_0000;
  localparam logic [31:0] OP_BEQ = 32'h0200_0000;
  localparam logic [31:0] OP_BNE = 32'h0400_0000;
  localparam logic [31:0] OP_J   = 32'h2000_0000;
  localparam logic [31:0] OP_JAL = 32'h4000_0000;

  multicycle_sequencer #(.WAIT_W(8), .MAX_WAIT(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .decoded_instr(decoded_instr),
    .alu_zero     (alu_zero),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .halt_req     (halt_req),
    .imem_req     (imem_req),
    .ir_w         (ir_w),
    .pc_w         (pc_w),
    .pc_sel       (pc_sel),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .regfile_w    (regfile_w),
    .state        (state),
    .instr_done   (instr_done),
    .fault        (fault),
    .halted       (halted)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {state, imem_req, ir_w, pc_w, pc_sel, dmem_req, dmem_we,
                regfile_w, instr_done, fault, halted};

  // Expected observation vector: state, imem_req, ir_w, pc_w, pc_sel, dmem_req,
  // dmem_we, regfile_w, instr_done, fault, halted.
  function automatic logic [13:0] ev(input int st, input int imr, input int irw, input int pcw,
                                     input int sel, input int dr, input int dwe, input int rf,
                                     input int dn, input int flt, input int hlt);
    return {st[2:0], imr[0], irw[0], pcw[0], sel[1:0], dr[0], dwe[0], rf[0], dn[0], flt[0], hlt[0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    decoded_instr = 32'd0;
    alu_zero      = 1'b0;
    imem_ready    = 1'b1;
    dmem_ready    = 1'b0;
    halt_req      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n         = 1'b0;
    decoded_instr = 32'd0;
    alu_zero      = 1'b0;
    imem_ready    = 1'b0;
    dmem_ready    = 1'b0;
    halt_req      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 14'd0) $display("FAIL reset_hold: got %h expected %h", obs, 14'd0);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    imem_ready    = 1'b1;
    decoded_instr = OP_ADD;
    @(negedge clk);
    n_checks++;
    if (obs !== ev(0,0,0,0,0,0,0,0,0,0,0)) $display("FAIL reset_idle: got %h expected %h", obs, 14'd0);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [13:0] ex [5];
    ex[0] = ev(1,1,1,1,0,0,0,0,0,0,0);
    ex[1] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(3,0,0,0,0,0,0,0,0,0,0);
    ex[3] = ev(5,0,0,0,0,0,0,1,1,0,0);
    ex[4] = ev(1,1,1,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL add_cyc%0d: got %h expected %h", i, obs, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lw();
    logic [13:0] ex [8];
    decoded_instr = OP_LW;
    dmem_ready    = 1'b0;
    ex[0] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(3,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(4,0,0,0,0,1,0,0,0,0,0);
    ex[3] = ev(4,0,0,0,0,1,0,0,0,0,0);
    ex[4] = ev(4,0,0,0,0,1,0,0,0,0,0);
    ex[5] = ev(4,0,0,0,0,1,0,0,0,0,0);
    ex[6] = ev(5,0,0,0,0,0,0,1,1,0,0);
    ex[7] = ev(1,1,1,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL lw_cyc%0d: got %h expected %h", i, obs, ex[i]);
      else n_pass++;
      if (i == 5) dmem_ready = 1'b1;
      if (i == 6) dmem_ready = 1'b0;
    end
  endtask

  task automatic test_sw();
    logic [13:0] ex [4];
    decoded_instr = OP_SW;
    dmem_ready    = 1'b1;
    ex[0] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(3,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(4,0,0,0,0,1,1,0,1,0,0);
    ex[3] = ev(1,1,1,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL sw_cyc%0d: got %h expected %h", i, obs, ex[i]);
      else n_pass++;
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_branch();
    logic [13:0] ex [6];
    decoded_instr = OP_BEQ;
    alu_zero      = 1'b1;
    ex[0] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(3,0,0,1,2,0,0,0,1,0,0);
    ex[2] = ev(1,1,1,1,0,0,0,0,0,0,0);
    ex[3] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[4] = ev(3,0,0,0,0,0,0,0,1,0,0);
    ex[5] = ev(1,1,1,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL branch_cyc%0d: got %h expected %h", i, obs, ex[i]);
      else n_pass++;
      if (i == 2) decoded_instr = OP_BNE;
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [13:0] ex [7];
    decoded_instr = OP_JAL;
    dmem_ready    = 1'b1;
    ex[0] = ev(2,0,0,1,3,0,0,0,0,0,0);
    ex[1] = ev(5,0,0,0,0,0,0,1,1,0,0);
    ex[2] = ev(1,1,1,1,0,0,0,0,0,0,0);
    ex[3] = ev(2,0,0,1,1,0,0,0,1,0,0);
    ex[4] = ev(1,1,1,1,0,0,0,0,0,0,0);
    ex[5] = ev(2,0,0,1,3,0,0,0,1,0,0);
    ex[6] = ev(1,1,1,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL jump_cyc%0d: got %h expected %h", i, obs, ex[i]);
      else n_pass++;
      if (i == 2) decoded_instr = OP_JR;
      if (i == 4) decoded_instr = OP_J;
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_halt();
    logic [13:0] ex [6];
    decoded_instr = OP_ADD;
    ex[0] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(3,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(5,0,0,0,0,0,0,1,1,0,0);
    ex[3] = ev(6,0,0,0,0,0,0,0,0,0,1);
    ex[4] = ev(6,0,0,0,0,0,0,0,0,0,1);
    ex[5] = ev(1,1,1,1,0,0,0,0,0,0,0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL halt_cyc%0d: got %h expected %h", i, obs, ex[i]);
      else n_pass++;
      if (i == 1) halt_req = 1'b1;
      if (i == 4) halt_req = 1'b0;
    end
  endtask

  task automatic test_watchdog();
    int bad;
    decoded_instr = OP_J;
    @(negedge clk);
    n_checks++;
    if (obs !== ev(2,0,0,1,3,0,0,0,1,0,0)) $display("FAIL wd_j1: got %h expected %h", obs, ev(2,0,0,1,3,0,0,0,1,0,0));
    else n_pass++;
    imem_ready = 1'b0;
    // ready in the 255th waiting cycle must still complete the fetch
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (obs !== ev(1,1,0,0,0,0,0,0,0,0,0)) bad++;
      if (i == 255) imem_ready = 1'b1;
    end
    n_checks++;
    if (bad != 0) $display("FAIL wd_wait_hold: got %0d bad cycles expected 0", bad);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (obs !== ev(2,0,0,1,3,0,0,0,1,0,0)) $display("FAIL wd_ready_last: got %h expected %h", obs, ev(2,0,0,1,3,0,0,0,1,0,0));
    else n_pass++;
    imem_ready = 1'b0;
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      @(negedge clk);
      if (obs !== ev(1,1,0,0,0,0,0,0,0,0,0)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL wd_timeout_hold: got %0d bad cycles expected 0", bad);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (obs !== ev(7,0,0,0,0,0,0,0,0,1,0)) $display("FAIL wd_fault: got %h expected %h", obs, ev(7,0,0,0,0,0,0,0,0,1,0));
    else n_pass++;
    imem_ready = 1'b1;
    halt_req   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== ev(7,0,0,0,0,0,0,0,0,1,0)) $display("FAIL wd_sticky: got %h expected %h", obs, ev(7,0,0,0,0,0,0,0,0,1,0));
    else n_pass++;
    halt_req = 1'b0;
  endtask

  task automatic test_decode_fault();
    logic [31:0] bad_ops [2];
    logic [13:0] ex [4];
    bad_ops[0] = 32'h0000_0000;
    bad_ops[1] = 32'h0000_0C00;
    ex[0] = ev(1,1,1,1,0,0,0,0,0,0,0);
    ex[1] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[2] = ev(7,0,0,0,0,0,0,0,0,1,0);
    ex[3] = ev(7,0,0,0,0,0,0,0,0,1,0);
    for (int k = 0; k < 2; k++) begin
      do_reset();
      decoded_instr = bad_ops[k];
      @(negedge clk);
      n_checks++;
      if (obs !== 14'd0) $display("FAIL dec%0d_idle: got %h expected %h", k, obs, 14'd0);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== ex[i]) $display("FAIL dec%0d_cyc%0d: got %h expected %h", k, i, obs, ex[i]);
        else n_pass++;
        if (i == 2) decoded_instr = OP_ADD;
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [13:0] ex [5];
    do_reset();
    decoded_instr = OP_LW;
    ex[0] = ev(0,0,0,0,0,0,0,0,0,0,0);
    ex[1] = ev(1,1,1,1,0,0,0,0,0,0,0);
    ex[2] = ev(2,0,0,0,0,0,0,0,0,0,0);
    ex[3] = ev(3,0,0,0,0,0,0,0,0,0,0);
    ex[4] = ev(4,0,0,0,0,1,0,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== ex[i]) $display("FAIL rmem_cyc%0d: got %h expected %h", i, obs, ex[i]);
      else n_pass++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 14'd0) $display("FAIL rmem_async: got %h expected %h", obs, 14'd0);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 14'd0) $display("FAIL rmem_idle: got %h expected %h", obs, 14'd0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (obs !== ev(1,1,1,1,0,0,0,0,0,0,0)) $display("FAIL rmem_if: got %h expected %h", obs, ev(1,1,1,1,0,0,0,0,0,0,0));
    else n_pass++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_halt();
    test_watchdog();
    test_decode_fault();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
